// File: rtl/io_responder_if.sv
// Host/core-facing signal bundle for io_responder: host sample stream, core
// request/data, and the result stream back to the host.
interface io_responder_if #(
  parameter int DW = 31
);
  logic signed [DW-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [3:0]           req_in;
  logic signed [DW-1:0] io_in;
  logic signed [DW-1:0] io_out;
  logic [3:0]           out_en;
  logic signed [DW-1:0] m_data;
  logic [3:0]           m_addr;
  logic                 m_valid;
  logic                 m_ready;
  logic                 in_underrun;
  logic                 out_overflow;

  modport slave (
    input  s_data, s_valid, req_in, io_out, out_en, m_ready,
    output s_ready, io_in, m_data, m_addr, m_valid, in_underrun, out_overflow
  );

  modport master (
    output s_data, s_valid, req_in, io_out, out_en, m_ready,
    input  s_ready, io_in, m_data, m_addr, m_valid, in_underrun, out_overflow
  );
endinterface

// File: rtl/io_responder.sv
// Host <-> core I/O responder: input FIFO feeding a registered io_in word and an
// output FIFO collecting {out_en, io_out}. Define IO_RESPONDER_STATS_EN for counters.
module io_responder #(
  parameter int DW    = 31,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
`ifdef IO_RESPONDER_STATS_EN
  output logic [15:0] in_count,
  output logic [15:0] out_count,
`endif
  io_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0]    addr;
    logic [DW-1:0] data;
  } res_t;

  logic [DW-1:0] in_mem_q [DEPTH];
  logic [AW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;

  res_t          out_mem_q [DEPTH];
  logic [AW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  logic [DW-1:0] io_in_q, io_in_d;
  logic          under_q, under_d, over_q, over_d;

  logic in_push, in_pop, out_push, out_pop, out_full, req_act, oe_act;
  res_t out_head;

  assign req_act  = (bus.req_in != 4'd0);
  assign oe_act   = (bus.out_en != 4'd0);
  assign in_push  = bus.s_valid && bus.s_ready;
  assign in_pop   = req_act && (in_cnt_q != '0);
  assign out_full = (out_cnt_q == CW'(DEPTH));
  assign out_pop  = bus.m_valid && bus.m_ready;
  // A full output FIFO still accepts when the host drains the head this cycle.
  assign out_push = oe_act && (!out_full || out_pop);
  assign out_head = out_mem_q[out_rd_q];

  assign bus.s_ready      = (in_cnt_q != CW'(DEPTH));
  assign bus.m_valid      = (out_cnt_q != '0);
  // Gate the head so stale memory never shows after reset.
  assign bus.m_data       = bus.m_valid ? out_head.data : '0;
  assign bus.m_addr       = bus.m_valid ? out_head.addr : 4'd0;
  assign bus.io_in        = io_in_q;
  assign bus.in_underrun  = under_q;
  assign bus.out_overflow = over_q;

  always_comb begin
    in_wr_d   = in_wr_q;
    in_rd_d   = in_rd_q;
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    io_in_d   = io_in_q;
    under_d   = under_q;
    over_d    = over_q;
    in_cnt_d  = in_cnt_q + CW'(in_push) - CW'(in_pop);
    out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
    if (in_push) in_wr_d = in_wr_q + AW'(1);
    if (in_pop) begin
      in_rd_d = in_rd_q + AW'(1);
      io_in_d = in_mem_q[in_rd_q];
    end
    if (req_act && in_cnt_q == '0) under_d = 1'b1;
    if (out_push) out_wr_d = out_wr_q + AW'(1);
    if (out_pop)  out_rd_d = out_rd_q + AW'(1);
    if (oe_act && !out_push) over_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_cnt_q  <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
      io_in_q   <= '0;
      under_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      in_cnt_q  <= in_cnt_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
      io_in_q   <= io_in_d;
      under_q   <= under_d;
      over_q    <= over_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers/counts.
  always_ff @(posedge clk) begin
    if (!rst && in_push)  in_mem_q[in_wr_q]   <= bus.s_data;
    if (!rst && out_push) out_mem_q[out_wr_q] <= '{addr: bus.out_en, data: bus.io_out};
  end

`ifdef IO_RESPONDER_STATS_EN
  logic [15:0] in_count_q, in_count_d, out_count_q, out_count_d;

  always_comb begin
    in_count_d  = in_count_q;
    out_count_d = out_count_q;
    if (in_pop && in_count_q != 16'hFFFF)    in_count_d  = in_count_q + 16'd1;
    if (out_push && out_count_q != 16'hFFFF) out_count_d = out_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_count_q  <= '0;
      out_count_q <= '0;
    end else begin
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_count  = in_count_q;
  assign out_count = out_count_q;
`endif
endmodule

// File: tb/tb_io_responder.sv
// Randomized + directed bench for io_responder against a queue-based model.
module tb_io_responder;
  localparam int DW    = 31;
  localparam int DEPTH = 8;

  typedef logic [DW+3:0] oent_t;

  logic clk, rst;
  io_responder_if #(.DW(DW)) bus ();
`ifdef IO_RESPONDER_STATS_EN
  logic [15:0] in_count, out_count;
`endif

  io_responder #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
`ifdef IO_RESPONDER_STATS_EN
    .in_count(in_count),
    .out_count(out_count),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state: plain queues of words, sticky flags, delivered word.
  logic signed [DW-1:0] qin[$];
  oent_t                qout[$];
  logic signed [DW-1:0] m_io_in;
  logic                 m_under, m_over, live;
  int                   m_in_cnt, m_out_cnt;

  initial live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      qin.delete();
      qout.delete();
      m_io_in   = '0;
      m_under   = 1'b0;
      m_over    = 1'b0;
      m_in_cnt  = 0;
      m_out_cnt = 0;
      live      = 1'b1;
    end else if (live) begin
      bit push_ok, hpop;
      push_ok = bus.s_valid && (qin.size() < DEPTH);
      hpop    = (qout.size() != 0) && bus.m_ready;
      if (bus.req_in != 4'd0) begin
        if (qin.size() > 0) begin
          m_io_in = qin.pop_front();
          if (m_in_cnt < 65535) m_in_cnt++;
        end else m_under = 1'b1;
      end
      if (push_ok) qin.push_back(bus.s_data);
      if (hpop) void'(qout.pop_front());
      if (bus.out_en != 4'd0) begin
        if (qout.size() < DEPTH) begin
          qout.push_back({bus.out_en, bus.io_out});
          if (m_out_cnt < 65535) m_out_cnt++;
        end else m_over = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      logic signed [DW-1:0] hd;
      chk("s_ready", bus.s_ready, qin.size() < DEPTH);
      chk("m_valid", bus.m_valid, qout.size() != 0);
      chk("io_in", bus.io_in, m_io_in);
      chk("in_underrun", bus.in_underrun, m_under);
      chk("out_overflow", bus.out_overflow, m_over);
      if (qout.size() != 0) begin
        hd = qout[0][DW-1:0];
        chk("m_data", bus.m_data, hd);
        chk("m_addr", bus.m_addr, qout[0][DW+3:DW]);
      end
`ifdef IO_RESPONDER_STATS_EN
      chk("in_count", in_count, m_in_cnt);
      chk("out_count", out_count, m_out_cnt);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.req_in = 4'd0;
    bus.io_out = '0; bus.out_en = 4'd0; bus.m_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    cyc();
    do_reset();
    chk("rst io_in", bus.io_in, 0);
    chk("rst s_ready", bus.s_ready, 1);
    chk("rst m_valid", bus.m_valid, 0);
    chk("rst m_data", bus.m_data, 0);
    chk("rst m_addr", bus.m_addr, 0);
    chk("rst flags", {bus.in_underrun, bus.out_overflow}, 0);

    // Three host words out to the core in order.
    bus.s_valid = 1'b1;
    bus.s_data = 3;  cyc();
    bus.s_data = -5; cyc();
    bus.s_data = 7;  cyc();
    bus.s_valid = 1'b0;
    bus.req_in = 4'd1; cyc(); chk("seq io_in0", bus.io_in, 3);
    cyc(); chk("seq io_in1", bus.io_in, -5);
    cyc(); chk("seq io_in2", bus.io_in, 7);
    bus.req_in = 4'd0;
    chk("seq underrun", bus.in_underrun, 0);

    // Request on empty FIFO.
    do_reset();
    bus.req_in = 4'd2; cyc(); bus.req_in = 4'd0;
    chk("empty io_in", bus.io_in, 0);
    chk("empty underrun", bus.in_underrun, 1);
    cyc(); cyc();
    chk("underrun sticky", bus.in_underrun, 1);

    // Output overflow, then drain.
    do_reset();
    bus.out_en = 4'd1;
    for (int i = 1; i <= 9; i++) begin bus.io_out = i; cyc(); end
    bus.out_en = 4'd0;
    chk("ovf m_valid", bus.m_valid, 1);
    chk("ovf flag", bus.out_overflow, 1);
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain data", bus.m_data, i);
      chk("drain addr", bus.m_addr, 1);
      cyc();
    end
    bus.m_ready = 1'b0;
    chk("drain empty", bus.m_valid, 0);

    // Full output FIFO with same-cycle pop accepts the push.
    do_reset();
    bus.out_en = 4'd1;
    for (int i = 0; i < 8; i++) begin bus.io_out = 11 + i; cyc(); end
    bus.out_en = 4'd3; bus.io_out = 99; bus.m_ready = 1'b1; cyc();
    bus.out_en = 4'd0;
    chk("fullpop ovf", bus.out_overflow, 0);
    for (int i = 0; i < 8; i++) begin
      chk("fullpop data", bus.m_data, (i < 7) ? 12 + i : 99);
      chk("fullpop addr", bus.m_addr, (i < 7) ? 1 : 3);
      cyc();
    end
    chk("fullpop empty", bus.m_valid, 0);
    bus.m_ready = 1'b0;

    // Reset mid-stream discards buffered input.
    do_reset();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin bus.s_data = 40 + i; cyc(); end
    bus.s_valid = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrst s_ready", bus.s_ready, 1);
    bus.req_in = 4'd1; cyc(); bus.req_in = 4'd0;
    chk("midrst underrun", bus.in_underrun, 1);
    chk("midrst io_in", bus.io_in, 0);

`ifdef IO_RESPONDER_STATS_EN
    do_reset();
    bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin bus.s_data = i; cyc(); end
    bus.s_valid = 1'b0;
    bus.req_in = 4'd1;
    for (int i = 0; i < 5; i++) cyc();
    bus.req_in = 4'd0;
    bus.out_en = 4'd2;
    for (int i = 0; i < 2; i++) begin bus.io_out = i; cyc(); end
    bus.out_en = 4'd0;
    chk("stats in_count", in_count, 5);
    chk("stats out_count", out_count, 2);
`endif

    // Randomized phases with varying bias to hit full and empty corners.
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      int p_sv, p_rq, p_oe, p_mr;
      p_sv = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 50;
      p_rq = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 50;
      p_oe = (ph % 2 == 0) ? 80 : 30;
      p_mr = (ph % 2 == 0) ? 25 : 80;
      for (int c = 0; c < 500; c++) begin
        rst         = ($urandom_range(299) == 0);
        bus.s_valid = ($urandom_range(99) < p_sv);
        bus.s_data  = DW'($urandom);
        bus.req_in  = ($urandom_range(99) < p_rq) ? 4'($urandom_range(15, 1)) : 4'd0;
        bus.out_en  = ($urandom_range(99) < p_oe) ? 4'($urandom_range(15, 1)) : 4'd0;
        bus.io_out  = DW'($urandom);
        bus.m_ready = ($urandom_range(99) < p_mr);
        cyc();
      end
    end
    idle();
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
